// File: rtl/fifo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_pkg : shared FIFO width/depth defaults and the data word type
// Revision 1.0
// ------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_DEPTH  = 16;

  typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sync_buffer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_sync_buffer_if : fifo_in / fifo_out valid-ready channels plus occupancy
// Revision 1.0
// ------------------------------------------------------------------
interface fifo_sync_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);

  logic [DATA_W-1:0] data_in;
  logic              data_in_vld;
  logic              data_in_rdy;
  logic [DATA_W-1:0] data_out;
  logic              data_out_vld;
  logic              data_out_rdy;
  logic [CNT_W-1:0]  count;

  modport master (
    output data_in, data_in_vld, data_out_rdy,
    input  data_in_rdy, data_out, data_out_vld, count
  );

  modport slave (
    input  data_in, data_in_vld, data_out_rdy,
    output data_in_rdy, data_out, data_out_vld, count
  );

endinterface
`default_nettype wire

// File: rtl/fifo_sync_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_sync_mem : DEPTH x DATA_W storage, one write port, registered write-first read
// Revision 1.0
// ------------------------------------------------------------------
module fifo_sync_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A word written to the slot being read becomes the new head this edge.
  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_sync_buffer : first-word fall-through synchronous FIFO, count-based full/empty
// Revision 1.0
// ------------------------------------------------------------------
module fifo_sync_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  fifo_sync_buffer_if.slave bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             data_in_rdy_q, data_in_rdy_d;
  logic             data_out_vld_q, data_out_vld_d;
  logic             push;
  logic             pop;

  always_comb begin
    push     = bus.data_in_vld && data_in_rdy_q;
    pop      = data_out_vld_q && bus.data_out_rdy;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    // Both flags look ahead at the next occupancy so they can be registered.
    data_in_rdy_d  = (count_d < FULL_CNT);
    data_out_vld_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_in_rdy_q  <= 1'b0;
      data_out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_in_rdy_q  <= data_in_rdy_d;
      data_out_vld_q <= data_out_vld_d;
    end
  end

  fifo_sync_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_d),
    .rdata (bus.data_out)
  );

  assign bus.data_in_rdy  = data_in_rdy_q;
  assign bus.data_out_vld = data_out_vld_q;
  assign bus.count        = count_q;

endmodule
`default_nettype wire
